// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion controller (SubWord shared via sbox_req/sbox_gnt); KEYSCHED_CACHE_EN skips re-expansion of the stored key.
// Done 42 cycles after Start (1 on cache hit); a denied sbox grant stalls one cycle, no word is written.
module aes_key_sched_ctrl (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [127:0] Key_In,
  output logic         Busy,
  output logic         Done,
  input  logic [3:0]   RoundSel,
  output logic [127:0] RoundKey,
  output logic         sbox_req,
  input  logic         sbox_gnt,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic        sched_valid_q, sched_valid_d;
  logic [31:0] w_q [44];
  logic [31:0] w_d [44];

  logic [31:0] w_prev, w_back4, new_word;
  logic [7:0]  rcon;
  logic        word_en;
  logic        cache_hit;

`ifdef KEYSCHED_CACHE_EN
  logic [127:0] key_q, key_d;
  assign cache_hit = sched_valid_q && (Key_In == key_q);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    w_prev  = w_q[i_q - 6'd1];
    w_back4 = w_q[i_q - 6'd4];
    case (i_q[5:2])
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    if (i_q[1:0] == 2'd0) new_word = sbox_out ^ {rcon, 24'h0} ^ w_back4;
    else                  new_word = w_prev ^ w_back4;
  end

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    sched_valid_d = sched_valid_q;
    w_d           = w_q;
    sbox_req      = 1'b0;
    sbox_in       = 32'h0;
    word_en       = 1'b0;
`ifdef KEYSCHED_CACHE_EN
    key_d         = key_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) state_d = cache_hit ? DONE : LOAD;
      end
      LOAD: begin
        w_d[0]        = Key_In[127:96];
        w_d[1]        = Key_In[95:64];
        w_d[2]        = Key_In[63:32];
        w_d[3]        = Key_In[31:0];
        i_d           = 6'd4;
        // the old schedule is being overwritten, so stop exposing it
        sched_valid_d = 1'b0;
`ifdef KEYSCHED_CACHE_EN
        key_d         = Key_In;
`endif
        state_d       = EXPAND;
      end
      EXPAND: begin
        word_en = 1'b1;
        if (i_q[1:0] == 2'd0) begin
          sbox_req = 1'b1;
          sbox_in  = {w_prev[23:0], w_prev[31:24]};
          word_en  = sbox_gnt;
        end
        if (word_en) begin
          w_d[i_q] = new_word;
          i_d      = i_q + 6'd1;
          if (i_q == 6'd43) begin
            state_d       = DONE;
            sched_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      i_q           <= 6'd4;
      sched_valid_q <= 1'b0;
      for (int k = 0; k < 44; k++) w_q[k] <= 32'h0;
`ifdef KEYSCHED_CACHE_EN
      key_q         <= 128'h0;
`endif
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      sched_valid_q <= sched_valid_d;
      w_q           <= w_d;
`ifdef KEYSCHED_CACHE_EN
      key_q         <= key_d;
`endif
    end
  end

  assign Busy = (state_q == LOAD) || (state_q == EXPAND);
  assign Done = (state_q == DONE);

  always_comb begin
    RoundKey = 128'h0;
    if (sched_valid_q && (RoundSel <= 4'd10))
      RoundKey = {w_q[{RoundSel, 2'b00}], w_q[{RoundSel, 2'b01}],
                  w_q[{RoundSel, 2'b10}], w_q[{RoundSel, 2'b11}]};
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1: clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1: level request to expand the key on Key_In.
REQ-004 SHALL have port Key_In, input, 128: cipher key; bits [127:96] form w[0] and bits [31:0] form w[3].
REQ-005 SHALL have port Busy, output, 1: high in LOAD and EXPAND.
REQ-006 SHALL have port Done, output, 1: high in DONE only.
REQ-007 SHALL have port RoundSel, input, 4: selects which round key drives RoundKey.
REQ-008 SHALL have port RoundKey, output, 128: {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = RoundSel; w[4r] occupies [127:96].
REQ-009 SHALL have port sbox_req, output, 1: requests the shared SubWord unit.
REQ-010 SHALL have port sbox_gnt, input, 1: grant from the S-box arbiter, same cycle.
REQ-011 SHALL have port sbox_in, output, 32: RotWord(w[i-1]) while sbox_req is high, otherwise 0.
REQ-012 SHALL have port sbox_out, input, 32: combinational SubWord(sbox_in), valid when sbox_gnt is high.

Function
REQ-013 SHALL implement four states: IDLE, LOAD, EXPAND and DONE.
REQ-014 SHALL leave IDLE for LOAD when Start=1; IDLE SHALL otherwise hold.
REQ-015 SHALL, in LOAD, write Key_In into w[0..3], set index i=4, capture Key_In into the stored key, and go to EXPAND.
REQ-016 SHALL, in EXPAND, compute one word per granted cycle: w[i] = w[i-1] ^ w[i-4] when i mod 4 != 0.
REQ-017 SHALL, when i mod 4 = 0, compute w[i] = sbox_out ^ {Rcon[i/4], 24'h0} ^ w[i-4].
REQ-018 SHALL use Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 (hex).
REQ-019 SHALL assert sbox_req only in EXPAND with i mod 4 = 0.
REQ-020 SHALL, if sbox_gnt=0 while sbox_req=1, write no word, hold i and hold sbox_req (stall).
REQ-021 SHALL increment i after each written word and go to DONE after writing w[43]; sched_valid SHALL then set.
REQ-022 SHALL make Done first high exactly 42 cycles after the Start sample when there are no stalls (cycle 0 = Start sampled in IDLE), plus one cycle per stall.
REQ-023 SHALL hold DONE while Start=1 and return to IDLE on Start=0.
REQ-024 SHALL ignore Start and Key_In changes outside IDLE; an in-progress expansion uses the key latched in LOAD.
REQ-025 SHALL drive RoundKey combinationally from RoundSel in every state.
REQ-026 SHALL drive RoundKey = 0 when RoundSel > 10 or sched_valid = 0.

Reset
REQ-027 SHALL, on Reset, force state IDLE, i=4, Busy=0, Done=0, sbox_req=0, sched_valid=0 and clear all w[] and the stored key to 0.
REQ-028 SHALL, on Reset during EXPAND, abandon the partial schedule; RoundKey SHALL read 0 on the next cycle.
REQ-029 SHALL give Reset priority over Start in the same cycle.

Configuration
REQ-030 SHALL support macro KEYSCHED_CACHE_EN.
REQ-031 SHALL, when KEYSCHED_CACHE_EN is defined and in IDLE with Start=1, sched_valid=1 and Key_In equal to the stored key, go directly to DONE (Done high at cycle 1) with no sbox_req.
REQ-032 SHALL, when KEYSCHED_CACHE_EN is undefined, always take the IDLE->LOAD->EXPAND path, with no key comparator.

Verification
REQ-033 SHALL cover: Key_In=2b7e151628aed2a6abf7158809cf4f3c, Start=1, gnt tied 1 -> Done at cycle 42; RoundSel=1 -> a0fafe1788542cb123a339392a6c7605; RoundSel=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 SHALL cover: same key with sbox_gnt deasserted for 3 cycles at i=8 -> Done at cycle 45, keys identical to REQ-033, no word written during the stall.
REQ-035 SHALL cover: Reset pulsed at cycle 20 of an expansion -> next cycle IDLE, Done=0, RoundKey=0 for RoundSel=0.
REQ-036 SHALL cover: Start held after Done, Key_In changed -> RoundKey unchanged; Start=0 -> IDLE; RoundSel=11 -> 0.
REQ-037 SHALL cover (KEYSCHED_CACHE_EN): repeated Start with the same key -> Done at cycle 1 and sbox_req never high; a different key -> full 42-cycle expansion.
